// File: rtl/serial_link_tx_scheduler.sv
// serial_link_tx_scheduler
//   Credit-based TX scheduler for one serial link channel. Requesters
//   0..3 (AW, W, AR, R) are arbitrated round-robin onto the single send
//   path. Each data packet consumes one peer credit. Locally freed RX
//   credits ride on every packet. When enough returns have accumulated and
//   no data can go, a credit-only (TagIdle) packet is sent.
//
// Ports
//   clk_i, rst_i        clock, async active-high reset
//   req_valid_i/ready_o requester handshake (ready is one-hot, only in the
//                       cycle the link accepts a data packet)
//   send_*              packet toward the link layer (valid/ready handshake)
//   credits_in_*        credits returned by the peer
//   rx_consumed_i       local RX FIFO popped one entry
//   credits_avail_o     current TX credit count
//
// state        | meaning
// LinkSendIdle | arbitrate; a chosen packet is offered in the same cycle
// LinkSendBusy | offered packet stalled by the link; held until accepted
module serial_link_tx_scheduler #(
  parameter int NumCredits     = 8,
  parameter int NumReq         = 4,
  parameter int CreditForceThr = 3,
  localparam int CW   = $clog2(NumCredits) + 1,
  localparam int SelW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output logic              send_valid_o,
  input  logic              send_ready_i,
  output logic [3:0]        send_tag_o,
  output logic [SelW-1:0]   send_sel_o,
  output logic [CW-1:0]     send_credits_o,
  input  logic              credits_in_valid_i,
  input  logic [CW-1:0]     credits_in_i,
  input  logic              rx_consumed_i,
  output logic [CW-1:0]     credits_avail_o
);

  typedef enum logic [3:0] {
    TagIdle = 4'd0,
    TagAW   = 4'd1,
    TagW    = 4'd2,
    TagAR   = 4'd3,
    TagR    = 4'd4
  } tag_e;

  typedef enum logic {
    LinkSendIdle = 1'b0,
    LinkSendBusy = 1'b1
  } link_state_e;

  localparam logic [CW:0] MaxCredits = (CW+1)'(NumCredits);
  localparam logic [CW:0] ForceThr   = (CW+1)'(CreditForceThr);

  link_state_e     state_q, state_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   pending_q, pending_d;
  logic [SelW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SelW-1:0] busy_sel_q, busy_sel_d;
  logic            busy_data_q, busy_data_d;

  logic            pick_found;
  logic [SelW-1:0] pick_idx;
  logic [SelW-1:0] scan_idx;
  logic            cur_valid;
  logic            cur_data;
  logic [SelW-1:0] cur_sel;
  logic            hs;
  logic            data_hs;
  logic [CW:0]     credits_sum;
  logic            credit_overflow;
  logic [CW:0]     pending_sum;

  // Round-robin scan starting at rr_ptr_q; index wraps through the SelW-bit
  // adder, which relies on NumReq being a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = rr_ptr_q + SelW'(k);
      if (!pick_found && req_valid_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_sel_d  = busy_sel_q;
    busy_data_d = busy_data_q;
    cur_valid   = 1'b0;
    cur_data    = 1'b0;
    cur_sel     = '0;

    if (!rst_i) begin
      unique case (state_q)
        LinkSendIdle: begin
          if (credits_q != '0 && pick_found) begin
            cur_valid = 1'b1;
            cur_data  = 1'b1;
            cur_sel   = pick_idx;
          end else if ({1'b0, pending_q} >= ForceThr) begin
            // Credit-only packet: allowed with zero TX credits so the peer
            // can always get its slots back.
            cur_valid = 1'b1;
          end
          if (cur_valid && !send_ready_i) begin
            state_d     = LinkSendBusy;
            busy_sel_d  = cur_sel;
            busy_data_d = cur_data;
          end
        end
        LinkSendBusy: begin
          cur_valid = 1'b1;
          cur_data  = busy_data_q;
          cur_sel   = busy_sel_q;
          if (send_ready_i) state_d = LinkSendIdle;
        end
        default: state_d = LinkSendIdle;
      endcase
    end

    hs      = cur_valid && send_ready_i;
    data_hs = hs && cur_data;

    rr_ptr_d = data_hs ? cur_sel + SelW'(1) : rr_ptr_q;

    credits_sum = {1'b0, credits_q} - {{CW{1'b0}}, data_hs}
                + (credits_in_valid_i ? {1'b0, credits_in_i} : '0);
    credit_overflow = credits_sum > MaxCredits;
    credits_d = credit_overflow ? MaxCredits[CW-1:0] : credits_sum[CW-1:0];

    // Pending returns ship with this packet; a same-cycle pop starts the
    // next batch at one.
    pending_sum = (hs ? '0 : {1'b0, pending_q}) + {{CW{1'b0}}, rx_consumed_i};
    pending_d   = (pending_sum > MaxCredits) ? MaxCredits[CW-1:0] : pending_sum[CW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= LinkSendIdle;
      credits_q   <= MaxCredits[CW-1:0];
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      busy_sel_q  <= '0;
      busy_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_sel_q  <= busy_sel_d;
      busy_data_q <= busy_data_d;
    end
  end

  // Peer returning more credits than it has slots is a protocol error; the
  // counter is clamped so the channel keeps running.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!credit_overflow)
        else $warning("protocol: peer credit return exceeds slot count, clamped");
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (data_hs) req_ready_o[cur_sel] = 1'b1;
  end

  assign send_valid_o    = cur_valid;
  assign send_sel_o      = cur_sel;
  assign send_tag_o      = (cur_valid && cur_data) ? 4'(TagAW) + 4'(cur_sel) : 4'(TagIdle);
  assign send_credits_o  = cur_valid ? pending_q : '0;
  assign credits_avail_o = credits_q;

endmodule

// File: tb/tb_serial_link_tx_scheduler.sv
module tb_serial_link_tx_scheduler;

  localparam int NC  = 8;
  localparam int THR = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] req_valid_i;
  logic [3:0] req_ready_o;
  logic       send_valid_o;
  logic       send_ready_i;
  logic [3:0] send_tag_o;
  logic [1:0] send_sel_o;
  logic [3:0] send_credits_o;
  logic       credits_in_valid_i;
  logic [3:0] credits_in_i;
  logic       rx_consumed_i;
  logic [3:0] credits_avail_o;

  serial_link_tx_scheduler dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .send_valid_o       (send_valid_o),
    .send_ready_i       (send_ready_i),
    .send_tag_o         (send_tag_o),
    .send_sel_o         (send_sel_o),
    .send_credits_o     (send_credits_o),
    .credits_in_valid_i (credits_in_valid_i),
    .credits_in_i       (credits_in_i),
    .rx_consumed_i      (rx_consumed_i),
    .credits_avail_o    (credits_avail_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: a packet in flight is remembered as (sel, is_data);
  // counters are plain integers.
  int m_credits, m_pending, m_rr;
  bit m_inflight;
  int m_fl_sel;
  bit m_fl_data;

  int last_valid, last_tag, last_sel, last_cred, last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_credits  = NC;
    m_pending  = 0;
    m_rr       = 0;
    m_inflight = 0;
    m_fl_sel   = 0;
    m_fl_data  = 0;
  endtask

  // What the link should see this cycle given the model state and inputs.
  task automatic model_offer(output bit v, output int sel, output bit data);
    v = 0; sel = 0; data = 0;
    if (m_inflight) begin
      v = 1; sel = m_fl_sel; data = m_fl_data;
    end else begin
      if (m_credits > 0 && req_valid_i != 0) begin
        for (int k = 3; k >= 0; k--)
          if (req_valid_i[(m_rr + k) % 4]) sel = (m_rr + k) % 4;
        v = 1; data = 1;
      end else if (m_pending >= THR) begin
        v = 1;
      end
    end
  endtask

  task automatic model_commit(input bit v, input int sel, input bit data);
    bit accepted;
    accepted = v && send_ready_i;
    if (accepted && data) begin
      m_credits -= 1;
      m_rr = (sel + 1) % 4;
    end
    if (credits_in_valid_i) m_credits += credits_in_i;
    if (m_credits > NC) m_credits = NC;
    m_pending = (accepted ? 0 : m_pending) + rx_consumed_i;
    if (m_pending > NC) m_pending = NC;
    if (v && !accepted) begin
      m_inflight = 1; m_fl_sel = sel; m_fl_data = data;
    end else begin
      m_inflight = 0;
    end
  endtask

  // Inputs are already set (after the previous rising edge). Check at the
  // falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit v, data;
    int sel;
    @(negedge clk_i);
    model_offer(v, sel, data);
    last_valid = send_valid_o;
    last_tag   = send_tag_o;
    last_sel   = send_sel_o;
    last_cred  = send_credits_o;
    last_ready = req_ready_o;
    chk("send_valid", 32'(send_valid_o), 32'(v));
    chk("send_tag", 32'(send_tag_o), v && data ? 32'(sel + 1) : 32'd0);
    chk("send_sel", 32'(send_sel_o), v ? 32'(sel) : 32'd0);
    chk("send_credits", 32'(send_credits_o), v ? 32'(m_pending) : 32'd0);
    chk("req_ready", 32'(req_ready_o), (v && data && send_ready_i) ? (32'd1 << sel) : 32'd0);
    chk("credits_avail", 32'(credits_avail_o), 32'(m_credits));
    @(posedge clk_i);
    model_commit(v, sel, data);
    #1;
  endtask

  task automatic set_in(input logic [3:0] req, input logic rdy, input logic cv,
                        input logic [3:0] cin, input logic rxc);
    req_valid_i = req; send_ready_i = rdy; credits_in_valid_i = cv;
    credits_in_i = cin; rx_consumed_i = rxc;
  endtask

  initial begin
    rst_i = 1'b1;
    set_in(4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", 32'(send_valid_o), 32'd0);
    chk("reset_avail", 32'(credits_avail_o), 32'd8);
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_credits", 32'(send_credits_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 1: all requesters, link always ready: 0,1,2,3,0,1,2,3 then out of credits
    set_in(4'hF, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t1_grant", 32'(last_sel), 32'(i % 4));
      chk("t1_ready", 32'(last_ready), 32'd1 << (i % 4));
    end
    cycle();
    chk("t1_no_credit_valid", 32'(last_valid), 32'd0);
    chk("t1_avail", 32'(credits_avail_o), 32'd0);

    // 2: three pops with zero credits -> credit-only packet carrying 3
    set_in(4'h0, 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (3) cycle();
    chk("t2_below_thr", 32'(last_valid), 32'd0);
    set_in(4'h0, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t2_idle_valid", 32'(last_valid), 32'd1);
    chk("t2_idle_tag", 32'(last_tag), 32'd0);
    chk("t2_idle_creds", 32'(last_cred), 32'd3);
    cycle();
    chk("t2_pending_cleared", 32'(last_valid), 32'd0);
    chk("t2_avail_zero", 32'(credits_avail_o), 32'd0);

    // 3: refill, then stall a TagAR packet while req 0 rises
    set_in(4'h0, 1'b0, 1'b1, 4'd8, 1'b0);
    cycle();
    set_in(4'b0100, 1'b0, 1'b0, 4'd0, 1'b0);
    cycle();
    set_in(4'b0101, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (4) begin
      cycle();
      chk("t3_frozen_sel", 32'(last_sel), 32'd2);
      chk("t3_frozen_tag", 32'(last_tag), 32'd3);
    end
    set_in(4'b0101, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t3_accept", 32'(last_ready), 32'b0100);
    set_in(4'b1001, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t3_next3", 32'(last_sel), 32'd3);
    cycle();
    chk("t3_next0", 32'(last_sel), 32'd0);

    // 4: credits 5, pending 1; handshake + return 2 + pop together
    set_in(4'h0, 1'b0, 1'b0, 4'd0, 1'b1);
    cycle();
    set_in(4'b0001, 1'b1, 1'b1, 4'd2, 1'b1);
    cycle();
    chk("t4_old_pending", 32'(last_cred), 32'd1);
    set_in(4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t4_credits6", 32'(credits_avail_o), 32'd6);
    set_in(4'b0001, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t4_new_pending", 32'(last_cred), 32'd1);

    // 5: credits 5 -> 7, then over-return of 3 clamps at 8
    set_in(4'h0, 1'b0, 1'b1, 4'd2, 1'b0);
    cycle();
    set_in(4'h0, 1'b0, 1'b1, 4'd3, 1'b0);
    cycle();
    chk("t5_clamp", 32'(credits_avail_o), 32'd8);

    // 6: reset while Busy drops the packet; arbitration restarts at 0
    set_in(4'b0001, 1'b0, 1'b0, 4'd0, 1'b0);
    cycle();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(send_valid_o), 32'd0);
    chk("t6_rst_avail", 32'(credits_avail_o), 32'd8);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    set_in(4'h0, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t6_after_valid", 32'(last_valid), 32'd0);
    set_in(4'hF, 1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
    chk("t6_rr_from0", 32'(last_sel), 32'd0);

    // Random traffic against the model; returns never exceed free slots.
    for (int i = 0; i < 600; i++) begin
      set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, NC - m_credits)),
             1'($urandom_range(0, 1)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
